// File: rtl/cges_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cges_pattern_gen : multi-channel round-robin pattern generator that serves |
// | per-channel up/down/LFSR/hold counters onto a single valid/ready stream.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cges_pattern_gen #(
   parameter int WIDTH     = 6,
   parameter int NUM_CH    = 4,
   parameter int LFSR_TAPS = 'h30,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] wrap_max,
   input  logic             cges_ready,
   output logic             cges_valid,
   output logic [WIDTH-1:0] cges,
   output logic [CH_W-1:0]  cges_ch,
   output logic             cges_wrap
);

   localparam logic [1:0]       c_mode_up   = 2'b00;
   localparam logic [1:0]       c_mode_down = 2'b01;
   localparam logic [1:0]       c_mode_lfsr = 2'b10;
   localparam logic [WIDTH-1:0] c_taps      = WIDTH'(LFSR_TAPS);
   localparam logic [WIDTH-1:0] c_zero      = '0;
   localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
   localparam logic [CH_W-1:0]  c_last_ch   = CH_W'(NUM_CH - 1);
   localparam logic [CH_W-1:0]  c_ch_one    = CH_W'(1);

   logic [WIDTH-1:0] r_cnt [NUM_CH];
   logic [CH_W-1:0]  r_ptr;
   logic             r_valid;
   logic [WIDTH-1:0] r_sample;
   logic [CH_W-1:0]  r_ch;
   logic             r_wrap;

   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;
   logic             w_load;

   // A new sample may be loaded whenever the output slot is empty or being drained.
   assign w_load = en & (~r_valid | cges_ready);

   always_comb begin
      w_cur = c_zero;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_ptr == CH_W'(i)) begin
            w_cur = r_cnt[i];
         end
      end
   end

   always_comb begin
      w_next = w_cur;
      w_wrap = 1'b0;
      case (mode)
         c_mode_up: begin
            w_wrap = (w_cur >= wrap_max);
            w_next = w_wrap ? c_zero : w_cur + c_one;
         end
         c_mode_down: begin
            w_wrap = (w_cur == c_zero);
            w_next = w_wrap ? wrap_max : w_cur - c_one;
         end
         c_mode_lfsr: begin
            w_wrap = (w_cur == c_one);
            // The all-zero state is a lock-up for XOR feedback; kick it to 1.
            w_next = (w_cur == c_zero) ? c_one
                                       : {w_cur[WIDTH-2:0], ^(w_cur & c_taps)};
         end
         default: begin
            w_next = w_cur;
            w_wrap = 1'b0;
         end
      endcase
   end

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         always_ff @(posedge clk) begin
            if (reset_n) begin
               r_cnt[g] <= WIDTH'(g);
            end else if (w_load && (r_ptr == CH_W'(g))) begin
               r_cnt[g] <= w_next;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_ptr    <= '0;
         r_valid  <= 1'b0;
         r_sample <= c_zero;
         r_ch     <= '0;
         r_wrap   <= 1'b0;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_sample <= w_cur;
         r_ch     <= r_ptr;
         r_wrap   <= w_wrap;
         r_ptr    <= (r_ptr == c_last_ch) ? '0 : r_ptr + c_ch_one;
      end else if (cges_ready) begin
         r_valid  <= 1'b0;
      end
   end

   assign cges_valid = r_valid;
   assign cges       = r_sample;
   assign cges_ch    = r_ch;
   assign cges_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_cges_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cges_pattern_gen : directed bench for the 4-channel and 1-channel build |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cges_pattern_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en, en1;
   logic [1:0] mode, mode1;
   logic [5:0] wrap_max, wrap_max1;
   logic       ready, ready1;

   logic       valid, valid1;
   logic [5:0] cges, cges1;
   logic [1:0] ch;
   logic [0:0] ch1;
   logic       wrap, wrap1;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   cges_pattern_gen #(.WIDTH(6), .NUM_CH(4), .LFSR_TAPS('h30)) u_dut4 (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .mode       (mode),
      .wrap_max   (wrap_max),
      .cges_ready (ready),
      .cges_valid (valid),
      .cges       (cges),
      .cges_ch    (ch),
      .cges_wrap  (wrap)
   );

   cges_pattern_gen #(.WIDTH(6), .NUM_CH(1), .LFSR_TAPS('h30)) u_dut1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en1),
      .mode       (mode1),
      .wrap_max   (wrap_max1),
      .cges_ready (ready1),
      .cges_valid (valid1),
      .cges       (cges1),
      .cges_ch    (ch1),
      .cges_wrap  (wrap1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b1;
      en        = 1'b0;
      en1       = 1'b0;
      ready     = 1'b0;
      ready1    = 1'b1;
      mode      = 2'b00;
      mode1     = 2'b00;
      wrap_max  = 6'd0;
      wrap_max1 = 6'd0;
      tick();
      tick();
      reset_n = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({valid, ch, wrap, cges} !== 10'd0)
         $display("FAIL reset_dut4: got v=%0b ch=%0d w=%0b val=%0d exp all 0", valid, ch, wrap, cges);
      else n_pass++;
      n_total++;
      if ({valid1, ch1, wrap1, cges1} !== 9'd0)
         $display("FAIL reset_dut1: got v=%0b ch=%0d w=%0b val=%0d exp all 0", valid1, ch1, wrap1, cges1);
      else n_pass++;
   endtask

   task automatic test_up();
      int exp_v [20] = '{0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,0, 4,5,0,1};
      do_reset();
      mode = 2'b00; wrap_max = 6'd5; ready = 1'b1; en = 1'b1;
      n_total++;
      if (valid !== 1'b0) $display("FAIL up_latency: got valid=%0b exp 0", valid);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_total++;
         if (valid !== 1'b1 || ch !== 2'(i % 4) || cges !== 6'(exp_v[i]) ||
             wrap !== (exp_v[i] == 5))
            $display("FAIL up_seq[%0d]: got v=%0b ch=%0d val=%0d w=%0b exp v=1 ch=%0d val=%0d w=%0b",
                     i, valid, ch, cges, wrap, i % 4, exp_v[i], exp_v[i] == 5);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      int exp_ch [3] = '{2,3,0};
      int exp_v  [3] = '{2,3,1};
      do_reset();
      mode = 2'b00; wrap_max = 6'd5; ready = 1'b1; en = 1'b1;
      tick();
      tick();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (valid !== 1'b1 || ch !== 2'd1 || cges !== 6'd1 || wrap !== 1'b0)
            $display("FAIL stall_hold[%0d]: got v=%0b ch=%0d val=%0d exp v=1 ch=1 val=1", i, valid, ch, cges);
         else n_pass++;
      end
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (valid !== 1'b1 || ch !== 2'(exp_ch[i]) || cges !== 6'(exp_v[i]))
            $display("FAIL stall_resume[%0d]: got ch=%0d val=%0d exp ch=%0d val=%0d",
                     i, ch, cges, exp_ch[i], exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_down();
      int exp_v [17] = '{0,1,2,3, 3,0,1,2, 2,3,0,1, 1,2,3,0, 0};
      do_reset();
      mode = 2'b01; wrap_max = 6'd3; ready = 1'b1; en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         n_total++;
         if (valid !== 1'b1 || ch !== 2'(i % 4) || cges !== 6'(exp_v[i]) ||
             wrap !== (exp_v[i] == 0))
            $display("FAIL down_seq[%0d]: got ch=%0d val=%0d w=%0b exp ch=%0d val=%0d w=%0b",
                     i, ch, cges, wrap, i % 4, exp_v[i], exp_v[i] == 0);
         else n_pass++;
      end
   endtask

   task automatic test_lfsr_1ch();
      logic [5:0] s  [66];
      logic       sw [66];
      int bad_hs   = 0;
      int bad_rep  = 0;
      int n_wraps  = 0;
      int exp_head [8] = '{0,1,2,4,8,16,33,3};
      do_reset();
      mode1 = 2'b10; wrap_max1 = 6'd0; en1 = 1'b1;
      for (int i = 0; i < 66; i++) begin
         tick();
         s[i]  = cges1;
         sw[i] = wrap1;
         if (valid1 !== 1'b1 || ch1 !== 1'b0) bad_hs++;
      end
      en1 = 1'b0;
      n_total++;
      if (bad_hs != 0) $display("FAIL lfsr_valid_ch: got %0d bad samples exp 0", bad_hs);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (s[i] !== 6'(exp_head[i]))
            $display("FAIL lfsr_head[%0d]: got %0d exp %0d", i, s[i], exp_head[i]);
         else n_pass++;
      end
      for (int i = 2; i < 64; i++) begin
         if (s[i] == 6'd0 || s[i] == 6'd1) bad_rep++;
      end
      for (int i = 1; i < 64; i++) begin
         if (sw[i]) n_wraps++;
      end
      n_total++;
      if (bad_rep != 0) $display("FAIL lfsr_no_early_repeat: got %0d hits exp 0", bad_rep);
      else n_pass++;
      n_total++;
      if (s[64] !== 6'd1 || s[65] !== 6'd2)
         $display("FAIL lfsr_period: got s64=%0d s65=%0d exp 1 2", s[64], s[65]);
      else n_pass++;
      n_total++;
      if (n_wraps != 1 || sw[1] !== 1'b1 || sw[0] !== 1'b0)
         $display("FAIL lfsr_wrap: got %0d wraps sw1=%0b sw0=%0b exp 1 1 0", n_wraps, sw[1], sw[0]);
      else n_pass++;
   endtask

   task automatic test_en_drop();
      do_reset();
      mode = 2'b00; wrap_max = 6'd5; ready = 1'b1; en = 1'b1;
      tick();
      tick();
      ready = 1'b0; en = 1'b0;
      tick();
      tick();
      n_total++;
      if (valid !== 1'b1 || ch !== 2'd1 || cges !== 6'd1)
         $display("FAIL endrop_hold: got v=%0b ch=%0d val=%0d exp v=1 ch=1 val=1", valid, ch, cges);
      else n_pass++;
      ready = 1'b1;
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL endrop_accept: got valid=%0b exp 0", valid);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if (valid !== 1'b0) $display("FAIL endrop_idle: got valid=%0b exp 0", valid);
      else n_pass++;
      en = 1'b1;
      tick();
      n_total++;
      if (valid !== 1'b1 || ch !== 2'd2 || cges !== 6'd2)
         $display("FAIL endrop_resume: got v=%0b ch=%0d val=%0d exp v=1 ch=2 val=2", valid, ch, cges);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      mode = 2'b00; wrap_max = 6'd5; ready = 1'b1; en = 1'b1;
      tick();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      n_total++;
      if (valid !== 1'b0 || ch !== 2'd0 || cges !== 6'd0)
         $display("FAIL midrst_drop: got v=%0b ch=%0d val=%0d exp 0 0 0", valid, ch, cges);
      else n_pass++;
      reset_n = 1'b0;
      tick();
      n_total++;
      if (valid !== 1'b1 || ch !== 2'd0 || cges !== 6'd0)
         $display("FAIL midrst_first: got v=%0b ch=%0d val=%0d exp v=1 ch=0 val=0", valid, ch, cges);
      else n_pass++;
      tick();
      n_total++;
      if (valid !== 1'b1 || ch !== 2'd1 || cges !== 6'd1)
         $display("FAIL midrst_second: got v=%0b ch=%0d val=%0d exp v=1 ch=1 val=1", valid, ch, cges);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_up();
      test_stall();
      test_down();
      test_lfsr_1ch();
      test_en_drop();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
